// File: rtl/sram_port_arbiter_pkg.sv
// Shared state encoding and default widths for the two-port SRAM arbiter.
package sram_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    TURN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter_arb_pick2.sv
// Combinational two-way winner select. ARB_ROUND_ROBIN_EN: ties go to the
// pointed port; otherwise port 0 always wins a tie and no pointer input exists.
module arb_pick2 (
  input  logic [1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic       ptr,
`endif
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid = |req;
`ifdef ARB_ROUND_ROBIN_EN
    winner = (req == 2'b11) ? ptr : req[1];
`else
    winner = req[1] & ~req[0];
`endif
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of one SRAM controller handshake, with locked
// bursts. Macro ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic              sram_read,
  output logic              sram_write,
  output logic [ADDR_W-1:0] sram_address,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              sram_ready
);

  arb_state_e state_q, state_d;
  logic       req0, req1;
  logic       pick_valid, pick_winner;
  logic       gnt0, gnt1;

  assign req0 = p0_read | p0_write;
  assign req1 = p1_read | p1_write;

`ifdef ARB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // Point away from whichever port just released the bus through TURN.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == GNT0 && req0 && sram_ready && !p0_lock) ptr_d = 1'b1;
    if (state_q == GNT1 && req1 && sram_ready && !p1_lock) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`endif

  arb_pick2 u_pick (
    .req    ({req1, req0}),
`ifdef ARB_ROUND_ROBIN_EN
    .ptr    (ptr_q),
`endif
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_valid) state_d = pick_winner ? GNT1 : GNT0;
      GNT0: begin
        if (!req0)           state_d = IDLE;
        else if (sram_ready) state_d = p0_lock ? GNT0 : TURN;
      end
      GNT1: begin
        if (!req1)           state_d = IDLE;
        else if (sram_ready) state_d = p1_lock ? GNT1 : TURN;
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign gnt0 = (state_q == GNT0);
  assign gnt1 = (state_q == GNT1);

  // Outputs decode only from state, so an async reset drops strobes at once.
  always_comb begin
    sram_read    = 1'b0;
    sram_write   = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    if (gnt0) begin
      sram_write   = p0_write;
      sram_read    = p0_read & ~p0_write;
      sram_address = p0_address;
      sram_wdata   = p0_wdata;
    end else if (gnt1) begin
      sram_write   = p1_write;
      sram_read    = p1_read & ~p1_write;
      sram_address = p1_address;
      sram_wdata   = p1_wdata;
    end
  end

  assign p0_ready = gnt0 & req0 & sram_ready;
  assign p1_ready = gnt1 & req1 & sram_ready;
  assign p0_rdata = gnt0 ? sram_rdata : '0;
  assign p1_rdata = gnt1 ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: vector table, directed corner
// sequences and randomized traffic against an ownership-level reference model.
module tb_sram_port_arbiter;

  localparam logic [31:0] W0 = 32'h1111_2222;
  localparam logic [31:0] W1 = 32'hDEAD_BEEF;
  localparam logic [31:0] RD = 32'hCAFE_F00D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_read, p0_write, p0_lock, p1_read, p1_write, p1_lock;
  logic [31:0] p0_address, p0_wdata, p1_address, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata, sram_address, sram_wdata, sram_rdata;
  logic        p0_ready, p1_ready, sram_read, sram_write, sram_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: who owns the bus, whether this is the dead cycle, tie pointer
  int m_owner;
  bit m_dead;
  int m_ptr;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_read(p0_read), .p0_write(p0_write), .p0_lock(p0_lock),
    .p0_address(p0_address), .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_read(p1_read), .p1_write(p1_write), .p1_lock(p1_lock),
    .p1_address(p1_address), .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .sram_read(sram_read), .sram_write(sram_write), .sram_address(sram_address),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
  );

  typedef struct {
    bit p0r, p0w, p0l; logic [31:0] p0a;
    bit p1r, p1w, p1l; logic [31:0] p1a;
    bit srdy;
    bit erd, ewr; logic [31:0] eaddr; int egnt; bit er0, er1;
  } vec_t;

  vec_t vt [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit p0r, p0w, p0l, input logic [31:0] p0a,
                       input bit p1r, p1w, p1l, input logic [31:0] p1a, input bit srdy);
    p0_read = p0r; p0_write = p0w; p0_lock = p0l; p0_address = p0a;
    p1_read = p1r; p1_write = p1w; p1_lock = p1l; p1_address = p1a;
    sram_ready = srdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_strobes", {30'd0, sram_read, sram_write}, 32'd0);
    chk("reset_ready", {30'd0, p0_ready, p1_ready}, 32'd0);
    chk("reset_addr", sram_address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_owner = -1; m_dead = 0; m_ptr = 0;
  endtask

  // Compare this cycle's outputs against the model, then advance it one clock.
  task automatic model_cycle(input int cyc);
    bit go0, go1, rq0, rq1, rq, lk;
    logic [31:0] e_addr, e_wdata;
    bit e_rd, e_wr;
    go0 = (m_owner == 0);
    go1 = (m_owner == 1);
    rq0 = p0_read || p0_write;
    rq1 = p1_read || p1_write;
    e_wr = go0 ? p0_write : (go1 ? p1_write : 1'b0);
    e_rd = go0 ? (p0_read && !p0_write) : (go1 ? (p1_read && !p1_write) : 1'b0);
    e_addr  = go0 ? p0_address : (go1 ? p1_address : 32'd0);
    e_wdata = go0 ? p0_wdata   : (go1 ? p1_wdata   : 32'd0);
    chk($sformatf("rnd%0d_strobes", cyc), {30'd0, sram_read, sram_write}, {30'd0, e_rd, e_wr});
    chk($sformatf("rnd%0d_addr", cyc), sram_address, e_addr);
    chk($sformatf("rnd%0d_wdata", cyc), sram_wdata, e_wdata);
    chk($sformatf("rnd%0d_ready", cyc), {30'd0, p0_ready, p1_ready},
        {30'd0, go0 && rq0 && sram_ready, go1 && rq1 && sram_ready});
    chk($sformatf("rnd%0d_rdata", cyc), p0_rdata ^ p1_rdata,
        (go0 || go1) ? sram_rdata : 32'd0);
    if (m_dead) begin
      m_dead = 0;
    end else if (m_owner < 0) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (rq0 && rq1) m_owner = m_ptr;
`else
      if (rq0 && rq1) m_owner = 0;
`endif
      else if (rq0) m_owner = 0;
      else if (rq1) m_owner = 1;
    end else begin
      rq = (m_owner == 0) ? rq0 : rq1;
      lk = (m_owner == 0) ? p0_lock : p1_lock;
      if (!rq) m_owner = -1;
      else if (sram_ready && !lk) begin
        m_ptr = 1 - m_owner;
        m_owner = -1;
        m_dead = 1;
      end
    end
  endtask

  initial begin
    bit a0, a1;
    p0_wdata = W0; p1_wdata = W1; sram_rdata = RD;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          p0r p0w p0l p0a       p1r p1w p1l p1a      rdy  erd ewr eaddr     egnt er0 er1
    vt[0]  = '{1, 0, 0, 32'h100, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0};
    vt[1]  = '{1, 0, 0, 32'h100, 0, 0, 0, 32'h0,   0, 1, 0, 32'h100, 1, 0, 0};
    vt[2]  = '{1, 0, 0, 32'h100, 0, 0, 0, 32'h0,   0, 1, 0, 32'h100, 1, 0, 0};
    vt[3]  = '{1, 0, 0, 32'h100, 0, 0, 0, 32'h0,   1, 1, 0, 32'h100, 1, 1, 0};
    vt[4]  = '{0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0};
    vt[5]  = '{0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0};
    vt[6]  = '{1, 0, 1, 32'h200, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0};
    vt[7]  = '{1, 0, 1, 32'h200, 0, 1, 0, 32'h300, 0, 1, 0, 32'h200, 1, 0, 0};
    vt[8]  = '{1, 0, 1, 32'h200, 0, 1, 0, 32'h300, 1, 1, 0, 32'h200, 1, 1, 0};
    vt[9]  = '{1, 0, 0, 32'h204, 0, 1, 0, 32'h300, 0, 1, 0, 32'h204, 1, 0, 0};
    vt[10] = '{1, 0, 0, 32'h204, 0, 1, 0, 32'h300, 1, 1, 0, 32'h204, 1, 1, 0};
    vt[11] = '{0, 0, 0, 32'h0,   0, 1, 0, 32'h300, 0, 0, 0, 32'h0,   0, 0, 0};
    vt[12] = '{0, 0, 0, 32'h0,   0, 1, 0, 32'h300, 0, 0, 0, 32'h0,   0, 0, 0};
    vt[13] = '{0, 0, 0, 32'h0,   1, 1, 0, 32'h300, 0, 0, 1, 32'h300, 2, 0, 0};
    vt[14] = '{0, 0, 0, 32'h0,   1, 1, 0, 32'h300, 1, 0, 1, 32'h300, 2, 0, 1};
    vt[15] = '{0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0};
    vt[16] = '{0, 0, 0, 32'h0,   1, 0, 0, 32'h400, 0, 0, 0, 32'h0,   0, 0, 0};
    vt[17] = '{0, 0, 0, 32'h0,   1, 0, 0, 32'h400, 0, 1, 0, 32'h400, 2, 0, 0};
    vt[18] = '{0, 0, 0, 32'h0,   0, 0, 0, 32'h400, 1, 0, 0, 32'h400, 2, 0, 0};
    vt[19] = '{1, 0, 0, 32'h500, 0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0};
    vt[20] = '{1, 0, 0, 32'h500, 0, 0, 0, 32'h0,   0, 1, 0, 32'h500, 1, 0, 0};
    vt[21] = '{1, 0, 0, 32'h500, 0, 0, 0, 32'h0,   1, 1, 0, 32'h500, 1, 1, 0};
    vt[22] = '{0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0};

    do_reset();
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(vt[i].p0r, vt[i].p0w, vt[i].p0l, vt[i].p0a,
            vt[i].p1r, vt[i].p1w, vt[i].p1l, vt[i].p1a, vt[i].srdy);
      #1;
      chk($sformatf("vec%0d_read", i), {31'd0, sram_read}, {31'd0, vt[i].erd});
      chk($sformatf("vec%0d_write", i), {31'd0, sram_write}, {31'd0, vt[i].ewr});
      chk($sformatf("vec%0d_addr", i), sram_address, vt[i].eaddr);
      chk($sformatf("vec%0d_wdata", i), sram_wdata,
          (vt[i].egnt == 1) ? W0 : ((vt[i].egnt == 2) ? W1 : 32'd0));
      chk($sformatf("vec%0d_ready", i), {30'd0, p0_ready, p1_ready}, {30'd0, vt[i].er0, vt[i].er1});
      chk($sformatf("vec%0d_rdata0", i), p0_rdata, (vt[i].egnt == 1) ? RD : 32'd0);
      chk($sformatf("vec%0d_rdata1", i), p1_rdata, (vt[i].egnt == 2) ? RD : 32'd0);
      $display("vec %0d: read=%0b write=%0b addr=%h ready0=%0b ready1=%0b",
               i, sram_read, sram_write, sram_address, p0_ready, p1_ready);
    end

    // simultaneous requests in IDLE, twice
    do_reset();
    @(negedge clk); drive(1, 0, 0, 32'h600, 1, 0, 0, 32'h700, 0);
    @(negedge clk); #1;
    chk("tie1_addr", sram_address, 32'h600);
    sram_ready = 1'b1; #1;
    chk("tie1_ready0", {31'd0, p0_ready}, 32'd1);
    chk("tie1_ready1", {31'd0, p1_ready}, 32'd0);
    @(negedge clk); sram_ready = 1'b0; #1;
    chk("tie_turn_read", {31'd0, sram_read}, 32'd0);
    @(negedge clk);
    @(negedge clk); #1;
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie2_addr", sram_address, 32'h700);
`else
    chk("tie2_addr", sram_address, 32'h600);
`endif
    $display("tie: second grant addr=%h", sram_address);

    // reset while port 1 waits for sram_ready
    do_reset();
    @(negedge clk); drive(0, 0, 0, 32'h0, 1, 0, 0, 32'h800, 0);
    @(negedge clk); #1;
    chk("rst_gnt1_read", {31'd0, sram_read}, 32'd1);
    sram_ready = 1'b1;
    rst_n = 1'b0; #1;
    chk("rst_mid_read", {31'd0, sram_read}, 32'd0);
    chk("rst_mid_ready1", {31'd0, p1_ready}, 32'd0);
    chk("rst_mid_rdata1", p1_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 32'h900, 0, 0, 0, 32'h0, 0);
    @(negedge clk); #1;
    chk("rst_after_read", {31'd0, sram_read}, 32'd1);
    chk("rst_after_addr", sram_address, 32'h900);
    $display("reset mid-beat: post-release grant addr=%h", sram_address);

    // randomized traffic against the reference model
    do_reset();
    a0 = 0; a1 = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      a0 = a0 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 4);
      a1 = a1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 4);
      p0_write = a0 && $urandom_range(0, 2) == 0;
      p0_read  = a0 && (!p0_write || $urandom_range(0, 1) == 1);
      p1_write = a1 && $urandom_range(0, 2) == 0;
      p1_read  = a1 && (!p1_write || $urandom_range(0, 1) == 1);
      p0_lock  = $urandom_range(0, 9) < 3;
      p1_lock  = $urandom_range(0, 9) < 3;
      p0_address = $urandom; p1_address = $urandom;
      p0_wdata   = $urandom; p1_wdata   = $urandom;
      sram_rdata = $urandom;
      sram_ready = $urandom_range(0, 2) == 0;
      #1;
      model_cycle(c);
      if (c % 100 == 0)
        $display("rnd %0d: owner=%0d read=%0b write=%0b addr=%h", c, m_owner, sram_read, sram_write, sram_address);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
